// File: rtl/bram_loader_pkg.sv
// Shared types and defaults for the BRAM frame loader.
// FSM state encoding plus default sync marker and RAM address width.
package bram_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AHI,
        ALO,
        LEN,
        DATA,
        CHK,
        VERIFY,
        DONE
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam int         DEF_ADDR_W    = 11;

endpackage

// File: rtl/bram_loader.sv
// Frame loader: SYNC, ADDR_HI, ADDR_LO, LEN, data, CHK into one RAM port; LOADER_READBACK_EN adds a readback verify.
// Latency: each data byte is written one cycle after acceptance; done one cycle after CHK (LEN+1 more with readback).
// Backpressure: in_ready is low only in VERIFY and DONE; in_valid low stalls the frame indefinitely.
module bram_loader
    import bram_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter int         ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    input  logic [7:0]        mem_q,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [2:0]        ahi_q, ahi_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic              in_ready_q, in_ready_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

`ifdef LOADER_READBACK_EN
    logic [ADDR_W-1:0] start_q, start_d;
    logic [8:0]        len_q, len_d;
    logic [7:0]        chk_q, chk_d;
    logic [7:0]        rb_sum;
    assign rb_sum = sum_q + mem_q;
`else
    logic unused_mem_q;
    assign unused_mem_q = ^mem_q;
`endif

    logic        accept;
    logic [10:0] frame_addr;
    assign accept     = in_valid && in_ready_q;
    assign frame_addr = {ahi_q, in_data};

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ahi_d      = ahi_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        err_d      = err_q;
`ifdef LOADER_READBACK_EN
        start_d    = start_q;
        len_d      = len_q;
        chk_d      = chk_q;
`endif
        case (state_q)
            IDLE: if (accept && in_data == SYNC_BYTE) begin
                err_d   = 1'b0;
                sum_d   = 8'd0;
                state_d = AHI;
            end
            AHI: if (accept) begin
                ahi_d   = in_data[2:0];
                state_d = ALO;
            end
            ALO: if (accept) begin
                ptr_d   = ADDR_W'(frame_addr);
`ifdef LOADER_READBACK_EN
                start_d = ADDR_W'(frame_addr);
`endif
                state_d = LEN;
            end
            LEN: if (accept) begin
                cnt_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
`ifdef LOADER_READBACK_EN
                len_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
`endif
                state_d = DATA;
            end
            DATA: if (accept) begin
                mem_we_d   = 1'b1;
                mem_addr_d = ptr_q;
                mem_data_d = in_data;
                ptr_d      = ptr_q + ADDR_W'(1);
                sum_d      = sum_q + in_data;
                cnt_d      = cnt_q - 9'd1;
                if (cnt_q == 9'd1) state_d = CHK;
            end
            CHK: if (accept) begin
                if (in_data != sum_q) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
`ifdef LOADER_READBACK_EN
                    chk_d      = in_data;
                    mem_addr_d = start_q;
                    cnt_d      = 9'd0;
                    sum_d      = 8'd0;
                    state_d    = VERIFY;
`else
                    state_d    = DONE;
`endif
                end
            end
`ifdef LOADER_READBACK_EN
            // cnt_q is the VERIFY cycle index; mem_q lags the address by one cycle
            VERIFY: begin
                mem_addr_d = mem_addr_q + ADDR_W'(1);
                cnt_d      = cnt_q + 9'd1;
                if (cnt_q != 9'd0) sum_d = rb_sum;
                if (cnt_q == len_q) begin
                    if (rb_sum != chk_q) err_d = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d != VERIFY) && (state_d != DONE);
        cpu_hold_d = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            ahi_q      <= 3'd0;
            cnt_q      <= 9'd0;
            sum_q      <= 8'd0;
            in_ready_q <= 1'b1;
            mem_addr_q <= '0;
            mem_data_q <= 8'd0;
            mem_we_q   <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_READBACK_EN
            start_q    <= '0;
            len_q      <= 9'd0;
            chk_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ahi_q      <= ahi_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            in_ready_q <= in_ready_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_READBACK_EN
            start_q    <= start_d;
            len_q      <= len_d;
            chk_q      <= chk_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bram_loader.sv
// Bench for bram_loader: bench RAM model, write scoreboard, one task per scenario.
// LOADER_READBACK_EN also enables the corrupted-readback scenario.
module tb_bram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic [7:0]  mem_q;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [18:0] exp_q[$];
    logic [18:0] obs_q[$];
    logic [7:0]  payload_q[$];
    logic [7:0]  ram [0:2047];
    logic        corrupt_en = 1'b0;

`ifdef LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    always #5 clk = ~clk;

    bram_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_q    (mem_q),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr] ^ ((corrupt_en && mem_addr == 11'h021) ? 8'h01 : 8'h00);
    end

    always @(negedge clk) begin
        if (mem_we) obs_q.push_back({mem_addr, mem_data});
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++; miscompares++;
            $display("FAIL in_ready_timeout byte %h: in_ready stayed %b, wanted 1", b, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Sends a whole frame from payload_q; chk_flip != 0 corrupts the checksum byte.
    task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] chk_flip);
        logic [10:0] a;
        logic [7:0]  s = 8'd0;
        int n = payload_q.size();
        a = {hi[2:0], lo};
        send_byte(8'hA5); send_byte(hi); send_byte(lo); send_byte(8'(n));
        foreach (payload_q[i]) begin
            exp_q.push_back({a, payload_q[i]});
            a = a + 11'd1;
            s = s + payload_q[i];
            send_byte(payload_q[i]);
        end
        send_byte(s ^ chk_flip);
    endtask

    task automatic wait_done(output int cyc, output bit rdy_hi);
        cyc = 0; rdy_hi = 1'b0;
        @(negedge clk);
        while (!done && cyc < 1000) begin
            if (in_ready) rdy_hi = 1'b1;
            cyc++;
            @(negedge clk);
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout: done=%b after %0d cycles, wanted 1", done, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 7;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        if (mem_addr !== 11'd0) begin miscompares++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        if (mem_data !== 8'd0) begin miscompares++; $display("FAIL rst_mem_data got %h want 0", mem_data); end
        if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL rst_cpu_hold got %b want 0", cpu_hold); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
        if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [18:0] e, o;
        int cyc, d0;
        bit rdy_hi;
        d0 = done_cnt;
        payload_q = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h00, 8'h20, 8'h00);
        wait_done(cyc, rdy_hi);
        vectors += 3;
        if (err !== 1'b0) begin miscompares++; $display("FAIL basic_err got %b want 0", err); end
        if (cyc != (RB ? 4 : 0)) begin miscompares++; $display("FAIL basic_latency got %0d want %0d", cyc, RB ? 4 : 0); end
        if (rdy_hi) begin miscompares++; $display("FAIL basic_verify_ready got 1 want 0"); end
        @(negedge clk); #1;
        vectors += 2;
        if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); end
        if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL basic_cpu_hold_after got %b want 0", cpu_hold); end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_write_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL basic_write got %h:%h want %h:%h", o[18:8], o[7:0], e[18:8], e[7:0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wrap();
        logic [18:0] e, o;
        int cyc;
        bit rdy_hi;
        payload_q = '{8'h01, 8'h02, 8'h03};
        send_frame(8'h07, 8'hFE, 8'h00);
        wait_done(cyc, rdy_hi);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL wrap_err got %b want 0", err); end
        @(negedge clk); #1;
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL wrap_write_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL wrap_write got %h:%h want %h:%h", o[18:8], o[7:0], e[18:8], e[7:0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bad_chk();
        logic [18:0] e, o;
        int cyc, d0;
        bit rdy_hi;
        d0 = done_cnt;
        payload_q = '{8'h55};
        send_frame(8'h00, 8'h10, 8'h01);
        wait_done(cyc, rdy_hi);
        vectors += 2;
        if (err !== 1'b1) begin miscompares++; $display("FAIL badchk_err got %b want 1", err); end
        if (cyc != 0) begin miscompares++; $display("FAIL badchk_latency got %0d want 0", cyc); end
        repeat (3) @(negedge clk);
        #1;
        vectors += 2;
        if (err !== 1'b1) begin miscompares++; $display("FAIL badchk_sticky got %b want 1", err); end
        if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL badchk_done_pulses got %0d want 1", done_cnt - d0); end
        send_byte(8'hA5);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL badchk_sync_clear got %b want 0", err); end
        exp_q.push_back({11'h030, 8'h77});
        send_byte(8'h00); send_byte(8'h30); send_byte(8'h01); send_byte(8'h77); send_byte(8'h77);
        wait_done(cyc, rdy_hi);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL badchk_next_err got %b want 0", err); end
        @(negedge clk); #1;
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL badchk_write_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL badchk_write got %h:%h want %h:%h", o[18:8], o[7:0], e[18:8], e[7:0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_leading_garbage();
        logic [18:0] e, o;
        logic [7:0]  tail [6] = '{8'h01, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h65};
        int cyc, bad_hold;
        bit rdy_hi;
        send_byte(8'h00);
        vectors++;
        if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL garbage_hold0 got %b want 0", cpu_hold); end
        send_byte(8'hFF);
        vectors += 2;
        if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL garbage_hold1 got %b want 0", cpu_hold); end
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL garbage_writes got %0d want 0", obs_q.size()); end
        send_byte(8'hA5);
        exp_q.push_back({11'h100, 8'hAA});
        exp_q.push_back({11'h101, 8'hBB});
        bad_hold = 0;
        if (cpu_hold !== 1'b1) bad_hold++;
        for (int i = 0; i < 6; i++) begin
            send_byte(tail[i]);
            if (cpu_hold !== 1'b1) bad_hold++;
        end
        wait_done(cyc, rdy_hi);
        vectors += 2;
        if (bad_hold != 0) begin miscompares++; $display("FAIL garbage_hold_frame got %0d low samples want 0", bad_hold); end
        if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL garbage_hold_done got %b want 1", cpu_hold); end
        @(negedge clk); #1;
        vectors += 2;
        if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL garbage_hold_idle got %b want 0", cpu_hold); end
        if (err !== 1'b0) begin miscompares++; $display("FAIL garbage_err got %b want 0", err); end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL garbage_write_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL garbage_write got %h:%h want %h:%h", o[18:8], o[7:0], e[18:8], e[7:0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall();
        logic [18:0] e, o;
        int cyc, bad;
        bit rdy_hi;
        exp_q.push_back({11'h050, 8'h0A});
        exp_q.push_back({11'h051, 8'h0B});
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h50); send_byte(8'h02); send_byte(8'h0A);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (in_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) bad++;
        end
        #1;
        vectors += 2;
        if (bad != 0) begin miscompares++; $display("FAIL stall_outputs got %0d bad cycles want 0", bad); end
        if (obs_q.size() != 1) begin miscompares++; $display("FAIL stall_writes got %0d want 1", obs_q.size()); end
        send_byte(8'h0B); send_byte(8'h15);
        wait_done(cyc, rdy_hi);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL stall_err got %b want 0", err); end
        @(negedge clk); #1;
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL stall_write_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL stall_write got %h:%h want %h:%h", o[18:8], o[7:0], e[18:8], e[7:0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [18:0] e, o;
        int cyc, d0;
        bit rdy_hi;
        d0 = done_cnt;
        payload_q.delete();
        for (int i = 0; i < 256; i++) payload_q.push_back(8'(i));
        send_frame(8'h03, 8'h00, 8'h00);
        payload_q = '{8'hC3, 8'h3C};
        send_frame(8'h07, 8'hFF, 8'h00);
        wait_done(cyc, rdy_hi);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL b2b_err got %b want 0", err); end
        @(negedge clk); #1;
        vectors += 2;
        if (done_cnt - d0 != 2) begin miscompares++; $display("FAIL b2b_done_pulses got %0d want 2", done_cnt - d0); end
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_write_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL b2b_write got %h:%h want %h:%h", o[18:8], o[7:0], e[18:8], e[7:0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [18:0] e, o;
        int bad, d0;
        d0 = done_cnt;
        exp_q.push_back({11'h040, 8'h01});
        exp_q.push_back({11'h041, 8'h02});
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h40); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors += 5;
        if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rstmid_mem_we got %b want 0", mem_we); end
        if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL rstmid_cpu_hold got %b want 0", cpu_hold); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        if (mem_addr !== 11'd0) begin miscompares++; $display("FAIL rstmid_mem_addr got %h want 0", mem_addr); end
        if (mem_data !== 8'd0) begin miscompares++; $display("FAIL rstmid_mem_data got %h want 0", mem_data); end
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_we !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0) bad++;
        end
        #1;
        vectors += 3;
        if (bad != 0) begin miscompares++; $display("FAIL rstmid_quiet got %0d bad cycles want 0", bad); end
        if (done_cnt - d0 != 0) begin miscompares++; $display("FAIL rstmid_done got %0d pulses want 0", done_cnt - d0); end
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rstmid_write_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL rstmid_write got %h:%h want %h:%h", o[18:8], o[7:0], e[18:8], e[7:0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef LOADER_READBACK_EN
    task automatic test_readback();
        logic [18:0] e, o;
        int cyc;
        bit rdy_hi;
        corrupt_en = 1'b1;
        payload_q = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h00, 8'h20, 8'h00);
        wait_done(cyc, rdy_hi);
        vectors += 3;
        if (err !== 1'b1) begin miscompares++; $display("FAIL readback_err got %b want 1", err); end
        if (cyc != 4) begin miscompares++; $display("FAIL readback_cycles got %0d want 4", cyc); end
        if (rdy_hi) begin miscompares++; $display("FAIL readback_in_ready got 1 want 0"); end
        @(negedge clk); #1;
        corrupt_en = 1'b0;
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL readback_write_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL readback_write got %h:%h want %h:%h", o[18:8], o[7:0], e[18:8], e[7:0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_bad_chk();
        test_leading_garbage();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef LOADER_READBACK_EN
        test_readback();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, wanted completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 SHALL expose parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL expose parameter ADDR_W, default 11, RAM byte address width (2K x 8).
REQ-003 SHALL expose: clk  input  1  sole clock, rising edge.
REQ-004 SHALL expose: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL expose: in_data  input  8  incoming byte stream.
REQ-006 SHALL expose: in_valid  input  1  in_data valid.
REQ-007 SHALL expose: in_ready  output  1  loader accepts a byte.
REQ-008 SHALL expose: mem_addr  output  ADDR_W  RAM port address.
REQ-009 SHALL expose: mem_data  output  8  RAM write data.
REQ-010 SHALL expose: mem_we  output  1  RAM write enable.
REQ-011 SHALL expose: mem_q  input  8  RAM read data, valid one clk after mem_addr.
REQ-012 SHALL expose: cpu_hold  output  1  holds the CPU off the RAM while loading.
REQ-013 SHALL expose: done  output  1  one-cycle pulse on frame completion.
REQ-014 SHALL expose: err  output  1  sticky frame error.

Function
REQ-015 Frame SHALL be: SYNC_BYTE, ADDR_HI (bits[2:0] used), ADDR_LO, LEN (0 means 256), LEN data bytes, CHK = 8-bit mod-256 sum of data bytes.
REQ-016 Byte transfer SHALL occur only on clk edge with in_valid && in_ready.
REQ-017 FSM states SHALL be IDLE, AHI, ALO, LEN, DATA, CHK, VERIFY, DONE.
REQ-018 IDLE: byte == SYNC_BYTE -> AHI and err cleared; any other byte discarded, stay IDLE.
REQ-019 AHI -> ALO -> LEN -> DATA, one accepted byte each; ptr loaded from {ADDR_HI[2:0], ADDR_LO}.
REQ-020 DATA: each accepted byte SHALL be written one cycle later (mem_we=1, mem_addr=ptr, mem_data=byte, registered); ptr increments, wrapping 2047 -> 0; after LEN bytes -> CHK.
REQ-021 CHK: mismatch -> err=1 and DONE; match -> VERIFY (macro on) or DONE (macro off).
REQ-022 in_ready SHALL be 1 in IDLE..CHK, 0 in VERIFY and DONE.
REQ-023 mem_we SHALL be 0 outside the cycle after a DATA acceptance; written bytes are never rolled back on error.
REQ-024 done SHALL pulse exactly one cycle in DONE, then IDLE, regardless of err.
REQ-025 cpu_hold SHALL be 1 in every state except IDLE.
REQ-026 in_valid low mid-frame SHALL stall the FSM indefinitely with no timeout.

Reset
REQ-027 rst SHALL force IDLE at the next edge, including mid-frame: in_ready=1, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=0, done=0, err=0, ptr and sum cleared.

Configuration
REQ-028 With LOADER_READBACK_EN defined, VERIFY SHALL re-read the LEN-byte range from the frame start address (mem_we=0, one address per cycle, wrap honoured), summing mem_q with one-cycle latency; a sum differing from CHK sets err; then DONE; VERIFY lasts LEN+1 cycles.
REQ-029 Without LOADER_READBACK_EN, VERIFY SHALL not exist, mem_q SHALL be unused, and CHK match goes directly to DONE.

Structure
REQ-030 Package bram_loader_pkg SHALL hold the state enum, default SYNC_BYTE, and ADDR_W default.
REQ-031 Block SHALL be flat with no sub-module; the RAM is instantiated by the parent, and the loader drives one RAM port.

Verification
REQ-032 Frame A5 00 20 03 11 22 33 66 -> writes 0x020=11, 0x021=22, 0x022=33; done pulses once; err=0.
REQ-033 Frame A5 07 FE 03 01 02 03 06 -> writes 0x7FE=01, 0x7FF=02, 0x000=03 (wrap); err=0.
REQ-034 Frame A5 00 10 01 55 54 -> byte written to 0x010, err=1, done pulses; next SYNC clears err.
REQ-035 Bytes 00 FF then a valid frame -> leading bytes ignored, frame loads, cpu_hold high from AHI to DONE only.
REQ-036 rst asserted after the second data byte of LEN=4 -> IDLE next edge, no further mem_we, cpu_hold=0.
REQ-037 LOADER_READBACK_EN with a bench RAM corrupting address 0x021 -> err=1 after VERIFY; in_ready low throughout VERIFY.
